// File: rtl/neuron_output_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package     : neuron_output_stage_pkg
// Description : Shared typedefs, widths and helpers for the neuron output
//               stage. Holds data_type / double_data_type and the saturation
//               helper sat_t.
// Revision    : 1.0 - initial release
// ============================================================================
package neuron_output_stage_pkg;

    localparam int DW           = 16;
    localparam int FRAC_DEFAULT = 8;

    typedef logic signed [DW-1:0]   data_type;
    typedef logic signed [2*DW-1:0] double_data_type;
    // One bit wider than double_data_type so acc + scaled bias never overflows.
    typedef logic signed [2*DW:0]   wide_type;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index width, kept at least one bit so M=1 still has a legal vector.
    function automatic int idx_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Saturate a 2*DW+1 bit value to DW bits. The value fits when all bits
    // from the MSB down to bit DW-1 agree with the sign.
    function automatic data_type sat_t(input wide_type x);
        if ((&x[2*DW:DW-1]) || !(|x[2*DW:DW-1])) begin
            return x[DW-1:0];
        end else if (x[2*DW]) begin
            return {1'b1, {(DW-1){1'b0}}};
        end else begin
            return {1'b0, {(DW-1){1'b1}}};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_output_stage_if.sv
`default_nettype none
// ============================================================================
// Interface   : neuron_output_stage_if
// Description : Result stream from the neuron output stage to the next layer.
//               master drives out_data/out_idx/out_valid and samples
//               out_ready; slave is the consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface neuron_output_stage_if #(
    parameter int IDXW = 3
);
    import neuron_output_stage_pkg::*;

    data_type          out_data;
    logic [IDXW-1:0]   out_idx;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/neuron_output_stage_requant_relu.sv
`default_nettype none
// ============================================================================
// Module      : requant_relu
// Description : Combinational requantiser. Adds the Q.FRAC bias to a
//               2*FRAC-fraction sum, shifts back to FRAC fraction bits
//               (floor), saturates to data_type and optionally applies ReLU.
// Ports       : acc     - double_data_type accumulator sum
//               bias    - data_type bias
//               relu_en - clamp negative results to zero
//               res     - data_type result
// Revision    : 1.0 - initial release
// ============================================================================
module requant_relu
    import neuron_output_stage_pkg::*;
#(
    parameter int FRAC = FRAC_DEFAULT
) (
    input  double_data_type acc,
    input  data_type        bias,
    input  logic            relu_en,
    output data_type        res
);

    wide_type w_acc_ext;
    wide_type w_bias_ext;
    wide_type w_sum;
    wide_type w_scaled;
    data_type w_sat;

    assign w_acc_ext  = {acc[2*DW-1], acc};
    assign w_bias_ext = {{(DW+1){bias[DW-1]}}, bias};
    // Bias is aligned to the sum's 2*FRAC fraction before adding.
    assign w_sum      = w_acc_ext + (w_bias_ext <<< FRAC);
    assign w_scaled   = w_sum >>> FRAC;
    assign w_sat      = sat_t(w_scaled);
    assign res        = (relu_en && w_sat[DW-1]) ? '0 : w_sat;

endmodule
`default_nettype wire

// File: rtl/neuron_output_stage.sv
`default_nettype none
// ============================================================================
// Module      : neuron_output_stage
// Description : Captures M accumulator sums and biases on start, requantises
//               each with saturation and optional ReLU, and streams the M
//               results one per handshake over out_if, then pulses done.
// Ports       : clk     - clock, rising edge
//               reset   - synchronous, active-low
//               start   - one-cycle pulse, acc_in/bias/relu_en valid
//               acc_in  - M accumulator sums
//               bias    - M per-neuron biases
//               relu_en - ReLU for the whole pass, sampled with start
//               busy    - pass in progress
//               done    - one-cycle pulse after last element is accepted
//               out_if  - result stream (data, idx, valid, ready)
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_output_stage
    import neuron_output_stage_pkg::*;
#(
    parameter int M    = 5,
    parameter int FRAC = FRAC_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  double_data_type [0:M-1][0:0]  acc_in,
    input  data_type        [0:M-1][0:0]  bias,
    input  logic                          relu_en,
    output logic                          busy,
    output logic                          done,
    neuron_output_stage_if.master         out_if
);

    localparam int              IDXW       = idx_width(M);
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(M-1);

    state_t                        r_state;
    state_t                        w_state_nxt;
    double_data_type [0:M-1][0:0]  r_acc;
    data_type        [0:M-1][0:0]  r_bias;
    logic                          r_relu;
    logic [IDXW-1:0]               r_idx;
    logic [IDXW-1:0]               w_idx_nxt;
    data_type                      r_data;
    data_type                      w_data_nxt;
    logic                          w_latch;
    logic                          w_fire;
    logic [IDXW-1:0]               w_sel_idx;
    double_data_type               w_sel_acc;
    data_type                      w_sel_bias;
    logic                          w_sel_relu;
    data_type                      w_res;

    assign w_fire    = (r_state == ST_EMIT) && out_if.out_ready;
    // Element to preload on the next handshake; clamped so the mux never
    // indexes past the last neuron.
    assign w_sel_idx = (r_idx == c_last_idx) ? r_idx : r_idx + 1'b1;

    // In IDLE the first element is computed straight from the ports so it
    // is ready the cycle after start; afterwards the latched copy is used.
    always_comb begin
        w_sel_acc  = r_acc[w_sel_idx][0];
        w_sel_bias = r_bias[w_sel_idx][0];
        w_sel_relu = r_relu;
        if (r_state == ST_IDLE) begin
            w_sel_acc  = acc_in[0][0];
            w_sel_bias = bias[0][0];
            w_sel_relu = relu_en;
        end
    end

    requant_relu #(
        .FRAC    (FRAC)
    ) u_requant_relu (
        .acc     (w_sel_acc),
        .bias    (w_sel_bias),
        .relu_en (w_sel_relu),
        .res     (w_res)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_EMIT;
                    w_idx_nxt   = '0;
                    w_data_nxt  = w_res;
                end
            end
            ST_EMIT: begin
                if (w_fire) begin
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt  = w_sel_idx;
                        w_data_nxt = w_res;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx  <= '0;
            r_data <= '0;
            r_acc  <= '0;
            r_bias <= '0;
            r_relu <= 1'b0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_data <= w_data_nxt;
            if (w_latch) begin
                r_acc  <= acc_in;
                r_bias <= bias;
                r_relu <= relu_en;
            end
        end
    end

    assign out_if.out_valid = (r_state == ST_EMIT);
    assign out_if.out_data  = r_data;
    assign out_if.out_idx   = r_idx;
    assign busy             = (r_state != ST_IDLE);
    assign done             = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_neuron_output_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_output_stage
// Description : Self-checking bench for neuron_output_stage. A queue-based
//               model predicts the result stream from the arithmetic rules;
//               directed passes pin literal results; random traffic covers
//               stalls, ignored starts and mid-pass resets.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_neuron_output_stage;
    import neuron_output_stage_pkg::*;

    localparam int M    = 5;
    localparam int FRAC = 8;
    localparam int IDXW = idx_width(M);

    logic clk       = 1'b0;
    logic reset     = 1'b0;
    logic start     = 1'b0;
    logic relu_en   = 1'b0;
    logic out_ready = 1'b1;
    logic busy;
    logic done;
    double_data_type [0:M-1][0:0] acc_in;
    data_type        [0:M-1][0:0] bias;

    neuron_output_stage_if #(.IDXW(IDXW)) out_if ();
    assign out_if.out_ready = out_ready;

    neuron_output_stage #(
        .M       (M),
        .FRAC    (FRAC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .acc_in  (acc_in),
        .bias    (bias),
        .relu_en (relu_en),
        .busy    (busy),
        .done    (done),
        .out_if  (out_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of one element straight from the arithmetic definition:
    // floor((acc + bias*2^FRAC) / 2^FRAC), clamp to 16-bit signed, ReLU.
    function automatic logic [15:0] ref_f(input logic [31:0] a, input logic [15:0] b, input bit relu);
        longint s, q, r;
        s = longint'($signed(a)) + longint'($signed(b)) * (2**FRAC);
        r = ((s % (2**FRAC)) + (2**FRAC)) % (2**FRAC);
        q = (s - r) / (2**FRAC);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        if (relu && q < 0) q = 0;
        return q[15:0];
    endfunction

    // Model: queue of results still owed, position of the head, busy/done.
    logic [15:0] exp_q[$];
    int          m_pos  = 0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            exp_q.delete();
            m_pos  = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (exp_q.size() != 0) begin
            if (out_ready) begin
                void'(exp_q.pop_front());
                m_pos++;
                if (exp_q.size() == 0) m_done = 1'b1;
            end
        end else if (start) begin
            for (int i = 0; i < M; i++)
                exp_q.push_back(ref_f(acc_in[i][0], bias[i][0], relu_en));
            m_pos  = 0;
            m_busy = 1'b1;
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_if.out_valid), 32'(exp_q.size() != 0));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            if (exp_q.size() != 0) begin
                chk("out_data", 32'($unsigned(out_if.out_data)), 32'(exp_q[0]));
                chk("out_idx", 32'(out_if.out_idx), m_pos);
            end
        end
    end

    task automatic load_directed();
        acc_in[0][0] = 32'h0003_0000; bias[0][0] = 16'h0100;
        acc_in[1][0] = 32'h7FFF_0000; bias[1][0] = 16'h7FFF;
        acc_in[2][0] = 32'hFFFE_0000; bias[2][0] = 16'h0000;
        acc_in[3][0] = 32'h8000_0000; bias[3][0] = 16'h8000;
        acc_in[4][0] = 32'h0000_00FF; bias[4][0] = 16'hFFFF;
    endtask

    task automatic load_random();
        int mode;
        for (int i = 0; i < M; i++) begin
            mode = $urandom_range(0, 2);
            case (mode)
                0: acc_in[i][0] = $urandom;
                1: acc_in[i][0] = 32'($signed($urandom_range(0, 2097151)) - 1048576);
                default: acc_in[i][0] = {($urandom % 2 == 0) ? 8'h7F : 8'h80, 24'($urandom)};
            endcase
            bias[i][0] = 16'($urandom);
        end
    endtask

    // Pulse start for one edge; called just after a rising edge.
    task automatic pulse_start(input bit relu);
        start   = 1'b1;
        relu_en = relu;
        @(posedge clk); #1;
        start   = 1'b0;
        load_random();
    endtask

    logic [15:0] lit_off [0:M-1] = '{16'h0400, 16'h7FFF, 16'hFE00, 16'h8000, 16'hFFFF};
    logic [15:0] lit_on  [0:M-1] = '{16'h0400, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
    logic [3:0]  stall_pat = 4'b1001;

    initial begin
        bit seen;
        acc_in = '0;
        bias   = '0;

        // Pin the reference function against hand-worked values.
        chk("pin 0x400", 32'(ref_f(32'h0003_0000, 16'h0100, 1'b0)), 32'h0400);
        chk("pin +sat",  32'(ref_f(32'h7FFF_0000, 16'h7FFF, 1'b0)), 32'h7FFF);
        chk("pin -sat",  32'(ref_f(32'h8000_0000, 16'h8000, 1'b0)), 32'h8000);
        chk("pin floor", 32'(ref_f(32'h0000_00FF, 16'hFFFF, 1'b0)), 32'hFFFF);
        chk("pin relu",  32'(ref_f(32'hFFFE_0000, 16'h0000, 1'b1)), 32'h0000);

        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("reset out_data", 32'($unsigned(out_if.out_data)), 32'h0);
        chk("reset out_idx", 32'(out_if.out_idx), 32'h0);
        chk("reset out_valid", 32'(out_if.out_valid), 32'h0);

        // Directed pass, ReLU off, consumer always ready.
        @(posedge clk); #1;
        load_directed();
        pulse_start(1'b0);
        for (int k = 0; k < M; k++) begin
            @(negedge clk);
            chk("dir off data", 32'($unsigned(out_if.out_data)), 32'(lit_off[k]));
            chk("dir off idx", 32'(out_if.out_idx), k);
        end
        @(negedge clk);
        chk("dir off done", 32'(done), 32'h1);
        chk("dir off valid low", 32'(out_if.out_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Same data, ReLU on.
        load_directed();
        pulse_start(1'b1);
        for (int k = 0; k < M; k++) begin
            @(negedge clk);
            chk("dir on data", 32'($unsigned(out_if.out_data)), 32'(lit_on[k]));
        end
        repeat (3) @(posedge clk);
        #1;

        // Stall pattern 1,0,0,1 with a second start during EMIT.
        load_random();
        pulse_start(1'(($urandom % 2)));
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            out_ready = stall_pat[c % 4];
            start     = (c == 3);
            load_random();
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk("stall pass done seen", 32'(seen), 32'h1);
        repeat (3) @(posedge clk);
        #1;

        // Reset while element 2 is on the bus.
        load_random();
        pulse_start(1'b0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (out_if.out_valid && out_if.out_idx == IDXW'(2)) seen = 1'b1;
        end
        chk("reached idx 2", 32'(seen), 32'h1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid reset valid", 32'(out_if.out_valid), 32'h0);
        chk("mid reset busy", 32'(busy), 32'h0);
        chk("mid reset done", 32'(done), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        pulse_start(1'b0);
        @(negedge clk);
        chk("restart valid", 32'(out_if.out_valid), 32'h1);
        chk("restart idx", 32'(out_if.out_idx), 32'h0);
        repeat (8) @(posedge clk);
        #1;

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            load_random();
            start     = ($urandom % 5 == 0);
            relu_en   = 1'($urandom % 2);
            out_ready = ($urandom % 4 != 0);
            reset     = ($urandom % 200 != 0);
            @(posedge clk); #1;
        end
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
